// File: rtl/rr_arb4_stage.sv
// rr_arb4_stage: registered 4-source round-robin arbitration stage.
//
// Picks one of four valid/ready sources (A/B/C/D) with a rotating priority
// pointer, steers the winner's word through a mux4to1 driven by the grant
// index S, and registers it onto a single valid/ready output channel.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - synchronous active-low reset
//   req_valid  - per-source valid (bit0=A .. bit3=D)
//   req_ready  - per-source ready, one-hot or zero
//   A, B, C, D - source data words
//   S          - grant index (mux4to1 select)
//   Y          - registered output word
//   out_valid  - Y holds a valid beat
//   out_ready  - downstream accepts Y this cycle

module mux4to1 #(
    parameter int N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    input  logic [1:0]   S,
    output logic [N-1:0] Y
);
    always_comb begin
        unique case (S)
            2'd0:    Y = A;
            2'd1:    Y = B;
            2'd2:    Y = C;
            default: Y = D;
        endcase
    end
endmodule

module rr_arb4_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req_valid,
    output logic [3:0]   req_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    output logic [1:0]   S,
    output logic [N-1:0] Y,
    output logic         out_valid,
    input  logic         out_ready
);
    logic [N-1:0] r_y;
    logic         r_out_valid;
    logic [1:0]   r_last_grant;

    logic         w_load;
    logic         w_grant;
    logic [1:0]   w_chosen;
    logic         w_found;
    logic [1:0]   w_idx;
    logic [N-1:0] w_mux_y;

    assign w_load = !r_out_valid || out_ready;
    // Reset suppresses the source handshake so no beat is lost mid-reset.
    assign w_grant = rst_n && w_load && (req_valid != 4'b0000);

    // Cyclic scan starting just after the last grant; 2-bit wrap gives mod 4.
    always_comb begin
        w_chosen = r_last_grant;
        w_found  = 1'b0;
        w_idx    = r_last_grant;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_last_grant + 2'(i);
            if (!w_found && req_valid[w_idx]) begin
                w_chosen = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    assign S         = w_grant ? w_chosen : r_last_grant;
    assign req_ready = w_grant ? (4'b0001 << w_chosen) : 4'b0000;

    mux4to1 #(.N(N)) u_mux (
        .A (A),
        .B (B),
        .C (C),
        .D (D),
        .S (S),
        .Y (w_mux_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y          <= '0;
            r_out_valid  <= 1'b0;
            r_last_grant <= 2'd3;
        end else if (w_load) begin
            if (w_grant) begin
                r_y          <= w_mux_y;
                r_out_valid  <= 1'b1;
                r_last_grant <= w_chosen;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end
    end

    assign Y         = r_y;
    assign out_valid = r_out_valid;
endmodule

// File: tb/tb_rr_arb4_stage.sv
module tb_rr_arb4_stage;
    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [N-1:0] A, B, C, D;
    logic [1:0]   S;
    logic [N-1:0] Y;
    logic         out_valid;
    logic         out_ready;

    logic [N-1:0] dat [4];
    int tests;
    int fails;

    rr_arb4_stage #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .S         (S),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_ov cyc%0d got %b want 0", k, out_valid); end
            tests++; if (Y !== '0) begin fails++; $display("FAIL reset_y cyc%0d got %h want 0", k, Y); end
            tests++; if (S !== 2'd3) begin fails++; $display("FAIL reset_s cyc%0d got %0d want 3", k, S); end
            tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_rdy cyc%0d got %b want 0000", k, req_ready); end
        end
        rst_n = 1'b1;
        #1;
        tests++; if (S !== 2'd0) begin fails++; $display("FAIL reset_first_s got %0d want 0", S); end
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL reset_first_rdy got %b want 0001", req_ready); end
        tick();
        tests++; if (Y !== dat[0] || out_valid !== 1'b1) begin fails++; $display("FAIL reset_first_y got %h/%b want %h/1", Y, out_valid, dat[0]); end
    endtask

    task automatic test_round_robin();
        int s_exp [5] = '{0, 1, 2, 3, 0};
        do_reset();
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            tests++; if (S !== 2'(s_exp[k])) begin fails++; $display("FAIL rr_s k%0d got %0d want %0d", k, S, s_exp[k]); end
            tests++; if (req_ready !== (4'b0001 << s_exp[k])) begin fails++; $display("FAIL rr_rdy k%0d got %b", k, req_ready); end
            if (k > 0) begin
                tests++; if (Y !== dat[s_exp[k-1]] || out_valid !== 1'b1) begin fails++; $display("FAIL rr_y k%0d got %h/%b want %h/1", k, Y, out_valid, dat[s_exp[k-1]]); end
            end else begin
                tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rr_ov0 got %b want 0", out_valid); end
            end
            tick();
        end
        tests++; if (Y !== dat[0] || out_valid !== 1'b1) begin fails++; $display("FAIL rr_y_last got %h/%b want %h/1", Y, out_valid, dat[0]); end
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0100;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            tests++; if (S !== 2'd2 || req_ready !== 4'b0100) begin fails++; $display("FAIL single_grant k%0d got S=%0d rdy=%b want 2/0100", k, S, req_ready); end
            if (k > 0) begin
                tests++; if (Y !== dat[2] || out_valid !== 1'b1) begin fails++; $display("FAIL single_y k%0d got %h/%b want %h/1", k, Y, out_valid, dat[2]); end
            end
            tick();
        end
    endtask

    task automatic test_idle();
        do_reset();
        req_valid = 4'b0001;
        out_ready = 1'b1;
        tick();
        req_valid = 4'b0000;
        #1;
        tests++; if (S !== 2'd0 || req_ready !== 4'b0000) begin fails++; $display("FAIL idle_s got S=%0d rdy=%b want 0/0000", S, req_ready); end
        tick();
        tests++; if (out_valid !== 1'b0 || Y !== dat[0]) begin fails++; $display("FAIL idle_hold got %h/%b want %h/0", Y, out_valid, dat[0]); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b1111;
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            req_valid = (k == 1) ? 4'b0001 : 4'b1111;
            #1;
            tests++; if (Y !== dat[1] || out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold k%0d got %h/%b want %h/1", k, Y, out_valid, dat[1]); end
            tests++; if (S !== 2'd1 || req_ready !== 4'b0000) begin fails++; $display("FAIL bp_s k%0d got S=%0d rdy=%b want 1/0000", k, S, req_ready); end
            tick();
        end
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        tests++; if (S !== 2'd2 || req_ready !== 4'b0100) begin fails++; $display("FAIL bp_release got S=%0d rdy=%b want 2/0100", S, req_ready); end
        tick();
        tests++; if (Y !== dat[2] || out_valid !== 1'b1) begin fails++; $display("FAIL bp_next_y got %h want %h", Y, dat[2]); end
    endtask

    task automatic test_sparse_wrap();
        int g [4] = '{3, 1, 3, 1};
        do_reset();
        req_valid = 4'b0010;
        out_ready = 1'b1;
        tick();
        req_valid = 4'b1010;
        #1;
        for (int k = 0; k < 4; k++) begin
            tests++; if (S !== 2'(g[k])) begin fails++; $display("FAIL sparse_s k%0d got %0d want %0d", k, S, g[k]); end
            tick();
            tests++; if (Y !== dat[g[k]]) begin fails++; $display("FAIL sparse_y k%0d got %h want %h", k, Y, dat[g[k]]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b1111;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL mid_rdy got %b want 0000", req_ready); end
        tick();
        tests++; if (out_valid !== 1'b0 || Y !== '0) begin fails++; $display("FAIL mid_clear got %h/%b want 0/0", Y, out_valid); end
        tests++; if (S !== 2'd3) begin fails++; $display("FAIL mid_s got %0d want 3", S); end
        rst_n = 1'b1;
        #1;
        tests++; if (S !== 2'd0 || req_ready !== 4'b0001) begin fails++; $display("FAIL mid_first got S=%0d rdy=%b want 0/0001", S, req_ready); end
        tick();
        tests++; if (Y !== dat[0] || out_valid !== 1'b1) begin fails++; $display("FAIL mid_y got %h/%b want %h/1", Y, out_valid, dat[0]); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        dat[0] = 32'hAAAA_AAAA;
        dat[1] = 32'hBBBB_BBBB;
        dat[2] = 32'hCCCC_CCCC;
        dat[3] = 32'hDDDD_DDDD;
        A = dat[0]; B = dat[1]; C = dat[2]; D = dat[3];
        rst_n = 1'b0;
        req_valid = 4'b0000;
        out_ready = 1'b0;

        test_reset();
        test_round_robin();
        test_single();
        test_idle();
        test_backpressure();
        test_sparse_wrap();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rr_arb4_stage.md
Name: rr_arb4_stage

Overview:
- Registered 4-source round-robin arbitration stage that sits directly upstream of mux4to1.
- Generates the 2-bit select S and uses it to choose among sources A/B/C/D.
- Presents the selected word on a single registered valid/ready output channel.
- Adds per-source valid/ready handshakes and fair sharing; it does not just steer a word combinationally.

Parameters:
N, 32, data width of each source and of the output word

Ports:
clk        input   1     clock, all state updates on rising edge
rst_n      input   1     synchronous active-low reset
req_valid  input   4     per-source valid; bit0=A, bit1=B, bit2=C, bit3=D
req_ready  output  4     per-source ready; one-hot or zero
A          input   N     source 0 data
B          input   N     source 1 data
C          input   N     source 2 data
D          input   N     source 3 data
S          output  2     current select/grant index (feeds mux4to1 select)
Y          output  N     registered output word
out_valid  output  1     Y holds a valid beat
out_ready  input   1     downstream accepts Y this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: out_valid=0, Y=0, last_grant=2'd3. After reset, S=3 and req_ready=4'b0000.
- Load condition: load = !out_valid || out_ready. Arbitration happens only when load=1.
- Arbitration:
  - When load=1 and req_valid!=0, chosen = first index with req_valid set, scanning cyclically from (last_grant+1) mod 4 (wrap 3->0).
  - S = chosen (combinational, same cycle).
  - req_ready[chosen]=1; all other bits 0.
- Idle: when load=1 and req_valid==0, S=last_grant and req_ready=0.
- Stall: when load=0 (out_valid=1, out_ready=0):
  - S=last_grant, req_ready=0.
  - Y, out_valid and last_grant hold.
  - req_valid changes have no effect.
- Transfer on an edge with load=1 and req_valid!=0:
  - Y <= {A,B,C,D}[chosen], selected via an internal mux4to1 instance driven by S.
  - out_valid <= 1.
  - last_grant <= chosen.
- Edge with load=1 and req_valid==0: out_valid <= 0. Y and last_grant hold.
- Latency: one cycle from source handshake (req_valid&req_ready) to Y/out_valid.
- Throughput: one beat per cycle when out_ready is held at 1.
- Simultaneous events: the output beat drains (out_ready=1) and a new beat loads on the same edge. No bubble.
- Fairness: a continuously valid source waits at most 3 grants before being served.
- Reset mid-operation: any held beat is discarded (out_valid=0 next edge) and the pointer returns to 3. The source handshake on that edge is not honoured, i.e. req_ready is treated as 0 while rst_n=0.
- Source rule: each source must keep its data stable while req_valid=1 and req_ready=0. The stage does not check this.

Test Plan:
1. Reset: rst_n=0 for 2 cycles, req_valid=4'b1111 -> out_valid=0, Y=0, S=3, req_ready=0000 throughout. First edge after release grants source 0.
2. Round-robin: A=AAAA_AAAA, B=BBBB_BBBB, C=CCCC_CCCC, D=DDDD_DDDD, req_valid=1111, out_ready=1 -> S sequence 0,1,2,3,0. Y sequence AAAA_AAAA, BBBB_BBBB, CCCC_CCCC, DDDD_DDDD, AAAA_AAAA one cycle later. out_valid=1 every cycle.
3. Single source: req_valid=0100, out_ready=1 -> S=2 and req_ready=0100 every cycle. Y=CCCC_CCCC continuously after 1 cycle.
4. Backpressure: with Y=BBBB_BBBB and out_valid=1, drop out_ready to 0 for 3 cycles -> Y, out_valid and S=1 hold, req_ready=0000. Raise out_ready -> next grant is 2 (C).
5. Sparse wrap: last_grant=1, req_valid=1010 -> grant 3 (Y=DDDD_DDDD), then grant 1 (Y=BBBB_BBBB), alternating.
6. Reset mid-stream: assert rst_n=0 for one edge while out_valid=1 and out_ready=0 -> out_valid=0, Y=0 next cycle. After release with req_valid=1111, grant 0 first.
